// File: rtl/fifo_rd_drain_if.sv
// FIFO read-port and output-stream bundle for fifo_rd_drain.
// master = the drain block; slave = the FIFO read port plus the downstream sink.
interface fifo_rd_drain_if #(
  parameter int DSIZE = 8
);
  logic             rd_empty;
  logic [DSIZE-1:0] rd_data;
  logic             rd_inc;
  logic             m_valid;
  logic [DSIZE-1:0] m_data;
  logic             m_ready;

  modport master (
    input  rd_empty,
    input  rd_data,
    input  m_ready,
    output rd_inc,
    output m_valid,
    output m_data
  );

  modport slave (
    output rd_empty,
    output rd_data,
    output m_ready,
    input  rd_inc,
    input  m_valid,
    input  m_data
  );
endinterface

// File: rtl/fifo_rd_drain.sv
// Pops a show-ahead FIFO into a 2-entry registered valid/ready buffer; pop-to-m_valid is 1 cycle.
// Stalls popping when the buffer is full and not draining; supports drain-to-empty with a done pulse.
module fifo_rd_drain #(
  parameter int DSIZE = 8,
  parameter int CNTW  = 16
) (
  input  logic                rd_clk,
  input  logic                rd_rst,
  input  logic                en,
  input  logic                drain_req,
  fifo_rd_drain_if.master     bus,
  output logic                drain_done,
  output logic                busy,
  output logic [CNTW-1:0]     pop_cnt
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [DSIZE-1:0] head_q, head_d;
  logic [DSIZE-1:0] tail_q, tail_d;
  logic [1:0]       occ_q, occ_d;
  logic [CNTW-1:0]  cnt_q, cnt_d;

  logic             popping;
  logic             out_xfer;
  logic             space;

  // Pop qualification; reset suppresses the strobe so no word leaves the FIFO into a buffer being cleared.
  always_comb begin
    out_xfer = (occ_q != 2'd0) && bus.m_ready;
    space    = (occ_q < 2'd2) || out_xfer;
    popping  = !rd_rst
               && ((state_q == ST_RUN) || (state_q == ST_DRAIN))
               && !bus.rd_empty
               && space;
  end

  assign bus.rd_inc  = popping;
  assign bus.m_valid = (occ_q != 2'd0);
  assign bus.m_data  = head_q;

  // Two-entry buffer: head feeds the output, tail catches the word behind it.
  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    occ_d  = occ_q;
    case ({popping, out_xfer})
      2'b10: begin
        if (occ_q == 2'd0) begin
          head_d = bus.rd_data;
        end else begin
          tail_d = bus.rd_data;
        end
        occ_d = occ_q + 2'd1;
      end
      2'b01: begin
        head_d = tail_q;
        occ_d  = occ_q - 2'd1;
      end
      2'b11: begin
        if (occ_q == 2'd2) begin
          head_d = tail_q;
          tail_d = bus.rd_data;
        end else begin
          head_d = bus.rd_data;
        end
      end
      default: begin
      end
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (drain_req) begin
          state_d = ST_DRAIN;
        end else if (en) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (drain_req) begin
          state_d = ST_DRAIN;
        end else if (!en) begin
          state_d = ST_IDLE;
        end
      end
      ST_DRAIN: begin
        // Finished only once nothing is left upstream, in the buffer, or in flight.
        if (bus.rd_empty && (occ_q == 2'd0) && !popping) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = en ? ST_RUN : ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_comb begin
    cnt_d = cnt_q;
    if (popping && (cnt_q != {CNTW{1'b1}})) begin
      cnt_d = cnt_q + CNTW'(1);
    end
  end

  always_ff @(posedge rd_clk) begin
    if (rd_rst) begin
      state_q <= ST_IDLE;
      head_q  <= '0;
      tail_q  <= '0;
      occ_q   <= 2'd0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      occ_q   <= occ_d;
      cnt_q   <= cnt_d;
    end
  end

  assign drain_done = (state_q == ST_DONE);
  assign busy       = (state_q != ST_IDLE);
  assign pop_cnt    = cnt_q;

endmodule
